// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared sizes and bus payload types for the CDB arbiter.
// Optional CDB_ARB_AGE_EN adds the age-limit constants used by urgent priority.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU_ALU  = 3;
    localparam int unsigned NUM_FU_MULT = 2;
    localparam int unsigned NUM_FU_LOAD = 1;
    localparam int unsigned NUM_REQ     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
    localparam int unsigned CDB_WIDTH   = 2;

    localparam int unsigned PRN_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROB_W  = 5;

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);

`ifdef CDB_ARB_AGE_EN
    localparam int unsigned AGE_LIMIT = 4;
    localparam int unsigned AGE_W     = $clog2(AGE_LIMIT + 1);
`endif

    // Completed result presented by a functional unit
    typedef struct packed {
        logic              valid;
        logic [PRN_W-1:0]  dest_prn;
        logic [DATA_W-1:0] value;
        logic [ROB_W-1:0]  robn;
    } fu_result_t;

    // One broadcast lane; robn rides along so the ROB can mark completion
    typedef struct packed {
        logic              valid;
        logic [PRN_W-1:0]  dest_prn;
        logic [DATA_W-1:0] value;
        logic [ROB_W-1:0]  robn;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr_psel.sv
// cdb_arbiter_rr_psel: rotating-priority selector granting up to GRANTS
// requests per cycle, scanning from ptr_i upward modulo WIDTH.
module cdb_arbiter_rr_psel #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned GRANTS = 2,
    localparam int unsigned PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned GW    = (GRANTS > 1) ? $clog2(GRANTS) : 1,
    localparam int unsigned CW    = $clog2(GRANTS + 1)
) (
    input  logic [WIDTH-1:0]              req_i,
    input  logic [PW-1:0]                 ptr_i,
    output logic [GRANTS-1:0][WIDTH-1:0]  gnt_o,
    output logic [GRANTS-1:0][PW-1:0]     idx_o,
    output logic [CW-1:0]                 cnt_o
);

    // k-th request found in scan order lands on lane k
    always_comb begin
        int unsigned idx;
        int unsigned cnt;
        gnt_o = '0;
        idx_o = '0;
        idx   = 0;
        cnt   = 0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= WIDTH) idx = idx - WIDTH;
            if (req_i[PW'(idx)] && (cnt < GRANTS)) begin
                gnt_o[GW'(cnt)][PW'(idx)] = 1'b1;
                idx_o[GW'(cnt)]           = PW'(idx);
                cnt = cnt + 1;
            end
        end
        cnt_o = CW'(cnt);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU one-entry result holds shared onto CDB_WIDTH broadcast
// lanes by rotating priority. Define CDB_ARB_AGE_EN to give holds that have
// waited AGE_LIMIT cycles urgent priority ahead of the rotating order.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  fu_result_t  [NUM_REQ-1:0]    fu_result,
    input  logic                         squash,
    output cdb_packet_t [CDB_WIDTH-1:0]  cdb_packet,
    output logic        [NUM_REQ-1:0]    fu_avail,
    output logic        [CNT_W-1:0]      pending_cnt
);

    localparam int unsigned LCNT_W = $clog2(CDB_WIDTH + 1);

    fu_result_t [NUM_REQ-1:0]          hold_q, hold_d;
    logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]                hold_vld;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                capture;
    logic [CDB_WIDTH-1:0][NUM_REQ-1:0] lane_gnt;
    logic [CDB_WIDTH-1:0][PTR_W-1:0]   lane_idx;
    logic [LCNT_W-1:0]                 lane_cnt;
    logic [PTR_W-1:0]                  last_idx;

    // Valid bits of all holds as a request vector
    always_comb begin
        hold_vld = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) hold_vld[i] = hold_q[i].valid;
    end

`ifdef CDB_ARB_AGE_EN
    localparam int unsigned LIDX_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

    logic [NUM_REQ-1:0][AGE_W-1:0]     age_q, age_d;
    logic [NUM_REQ-1:0]                urgent;
    logic [CDB_WIDTH-1:0][NUM_REQ-1:0] u_gnt, n_gnt;
    logic [CDB_WIDTH-1:0][PTR_W-1:0]   u_idx, n_idx;
    logic [LCNT_W-1:0]                 u_cnt, n_cnt;

    // Holds that have waited AGE_LIMIT cycles form the urgent set
    always_comb begin
        urgent = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            urgent[i] = hold_vld[i] && (age_q[i] >= AGE_W'(AGE_LIMIT));
    end

    cdb_arbiter_rr_psel #(.WIDTH(NUM_REQ), .GRANTS(CDB_WIDTH)) u_psel_urgent (
        .req_i (urgent),
        .ptr_i (rr_ptr_q),
        .gnt_o (u_gnt),
        .idx_o (u_idx),
        .cnt_o (u_cnt)
    );

    cdb_arbiter_rr_psel #(.WIDTH(NUM_REQ), .GRANTS(CDB_WIDTH)) u_psel_normal (
        .req_i (hold_vld & ~urgent),
        .ptr_i (rr_ptr_q),
        .gnt_o (n_gnt),
        .idx_o (n_idx),
        .cnt_o (n_cnt)
    );

    // Urgent grants take the low lanes, normal grants fill the rest
    always_comb begin
        int unsigned total;
        lane_gnt = '0;
        lane_idx = '0;
        total    = 32'(u_cnt) + 32'(n_cnt);
        for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
            if (l < 32'(u_cnt)) begin
                lane_gnt[l] = u_gnt[l];
                lane_idx[l] = u_idx[l];
            end else begin
                lane_gnt[l] = n_gnt[LIDX_W'(l - 32'(u_cnt))];
                lane_idx[l] = n_idx[LIDX_W'(l - 32'(u_cnt))];
            end
        end
        lane_cnt = (total > CDB_WIDTH) ? LCNT_W'(CDB_WIDTH) : LCNT_W'(total);
    end

    // Age counts cycles a valid hold sits ungranted, saturating at AGE_LIMIT
    always_comb begin
        age_d = age_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (squash || capture[i] || grant[i] || !hold_vld[i])
                age_d[i] = '0;
            else if (age_q[i] < AGE_W'(AGE_LIMIT))
                age_d[i] = age_q[i] + AGE_W'(1);
        end
    end

    // Age register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) age_q <= '0;
        else        age_q <= age_d;
    end
`else
    cdb_arbiter_rr_psel #(.WIDTH(NUM_REQ), .GRANTS(CDB_WIDTH)) u_psel (
        .req_i (hold_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (lane_gnt),
        .idx_o (lane_idx),
        .cnt_o (lane_cnt)
    );
`endif

    // Route granted holds onto lanes; squash suppresses every grant
    always_comb begin
        grant      = '0;
        cdb_packet = '0;
        if (!squash) begin
            for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
                if (lane_gnt[l] != '0) begin
                    grant                  = grant | lane_gnt[l];
                    cdb_packet[l].valid    = 1'b1;
                    cdb_packet[l].dest_prn = hold_q[lane_idx[l]].dest_prn;
                    cdb_packet[l].value    = hold_q[lane_idx[l]].value;
                    cdb_packet[l].robn     = hold_q[lane_idx[l]].robn;
                end
            end
        end
    end

    // An FU may issue when its hold is empty or drains this cycle
    always_comb begin
        fu_avail = squash ? '1 : (~hold_vld | grant);
        capture  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            capture[i] = fu_result[i].valid && fu_avail[i] && !squash;
    end

    assign pending_cnt = CNT_W'($countones(hold_vld));

    // Hold load/drain and rotating pointer advance past the last grant
    always_comb begin
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;
        last_idx = '0;
        if (squash) begin
            hold_d   = '0;
            rr_ptr_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (capture[i])    hold_d[i]       = fu_result[i];
                else if (grant[i]) hold_d[i].valid = 1'b0;
            end
            if (lane_cnt != '0) begin
                for (int unsigned l = 0; l < CDB_WIDTH; l++)
                    if (lane_gnt[l] != '0) last_idx = lane_idx[l];
                rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
            end
        end
    end

    // Hold and pointer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the `N common data bus lanes among all completing functional units (ALU, MULT, LOAD) and holds each result until it is broadcast.
- Each FU has a one-entry hold register. A rotating-priority scheduler grants up to CDB_WIDTH holds per cycle.
- Produces the per-FU availability bits that gate RS issue (fu_*_avail) and drives the CDB that wakes RS entries.

Parameters:
- NUM_REQ, `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD: number of result requesters. ALU indices come first, then MULT, then LOAD.
- CDB_WIDTH, `N: number of CDB lanes.
- AGE_LIMIT, 4: wait cycles after which a hold gains urgent priority (CDB_ARB_AGE_EN only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- fu_result  in  FU_RESULT[NUM_REQ-1:0]  per-FU result {valid, dest_prn, value, robn}
- squash  in  1  synchronous flush (mispredict); drops all pending results
- cdb_packet  out  CDB_PACKET[CDB_WIDTH-1:0]  broadcast lanes {valid, dest_prn, value}
- fu_avail  out  NUM_REQ  FU may accept a new RS issue this cycle; split externally into fu_alu/mult/load_avail
- pending_cnt  out  $clog2(NUM_REQ+1)  number of valid hold registers (debug/perf)

Behaviour:
- State: hold[NUM_REQ] (valid + payload), rr_ptr ($clog2(NUM_REQ) bits), age[NUM_REQ] (optional).
- Reset (reset==0, async):
  - All hold.valid=0, rr_ptr=0, age=0.
  - Outputs during reset: cdb_packet[*].valid=0, fu_avail=all 1s, pending_cnt=0.
- Capture: if fu_result[i].valid at cycle t, hold[i] loads it at the end of t. Earliest broadcast is cycle t+1, so the minimum latency is 1 cycle. There is no input-to-CDB bypass.
- Arbitration is combinational over hold.valid.
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first CDB_WIDTH valid holds found are granted. The k-th grant in scan order drives lane k.
  - Unused lanes have valid=0, and their other fields are 0.
- Drain: a granted hold clears at the edge unless fu_result[i].valid that cycle, in which case it reloads with the new result.
- fu_avail[i] = ~hold[i].valid | grant[i] (combinational). An FU must never present a result while fu_avail[i] was low in the cycle it issued. If it does, the new result is dropped and hold keeps the old one.
- rr_ptr update:
  - If at least one grant was made this cycle: rr_ptr <= (highest-scan-order granted index + 1) mod NUM_REQ.
  - No grants: rr_ptr unchanged.
  - Wrap-around is handled modulo NUM_REQ for non-power-of-2 sizes.
- Fairness: a waiting hold is granted within ceil(NUM_REQ/CDB_WIDTH) cycles.
- Squash cycle:
  - cdb_packet all invalid and no grants.
  - At the edge: all holds clear, inputs that cycle are discarded, rr_ptr <= 0, age <= 0.
  - fu_avail = all 1s during the squash cycle.
- pending_cnt = popcount(hold.valid), combinational from state.
- Full load: all NUM_REQ holds valid means exactly min(CDB_WIDTH, NUM_REQ) grants per cycle. Empty: no lanes valid, rr_ptr holds.

Optional Feature:
- CDB_ARB_AGE_EN defined:
  - Each valid, ungranted hold increments a saturating age counter (width $clog2(AGE_LIMIT+1)). Age resets on grant, capture or squash.
  - Holds with age ≥ AGE_LIMIT form an urgent set. Urgent holds are granted first, in rotating order from rr_ptr. Remaining lanes then fill from non-urgent holds in the normal rotating order.
  - rr_ptr updates from the last overall grant.
- Undefined: no age state; pure rotating priority as above.

Decomposition:
- sys_defs.svh gets:
  - FU_RESULT struct {valid, dest_prn PRN, value DATA, robn}.
  - CDB_PACKET extended if needed.
  - `NUM_FU_TOTAL macro.
- Sub-module rr_psel: rotating-priority multi-grant selector. Inputs: req[WIDTH], ptr, GRANTS. Outputs: per-lane one-hot grant buses and last-grant index. It is instantiated twice under CDB_ARB_AGE_EN (urgent/normal), once otherwise.

Test Plan (NUM_REQ=6, CDB_WIDTH=2):
- Reset mid-operation: 3 valid holds, drive reset=0 asynchronously between edges → cdb_packet valid=0 immediately, fu_avail=6'b111111, pending_cnt=0, rr_ptr=0.
- Single result: fu_result[3]={1,prn 7,value 32'hDEAD_BEEF} at t → lane0 {1,7,DEADBEEF} at t+1, lane1 invalid, fu_avail[3]=1 at t+1, rr_ptr=4 after t+1.
- Contention with wrap: holds 0,1,4,5 valid, rr_ptr=4 → grants 4→lane0, 5→lane1; next cycle 0→lane0, 1→lane1; rr_ptr 0 then 2; fu_avail[0]=fu_avail[1]=1 only in the cycle they are granted.
- Back-to-back reload: hold[2] valid and granted while fu_result[2].valid with value 5 → next cycle hold[2]=5, broadcast once, no lost or duplicated result.
- Squash: holds 1,2,3 valid, squash=1 → no CDB valid that cycle, next cycle pending_cnt=0, rr_ptr=0, inputs during the squash cycle are not broadcast.
- CDB_ARB_AGE_EN: all 6 requesters continuously refilled; check no hold waits more than AGE_LIMIT+3 cycles, and an urgent hold is granted lane0 ahead of a lower-age hold at rr_ptr.
